fdiv_issue_ctrl: RTL and testbench

Requester-side controller for the Newton-iteration FP divider: accepts divide requests from decode over valid/ready, drives the divider's fdiv/ena/operand interface, waits out its stall/busy iteration window and 3-stage exponent pipeline, then returns result, error code and tag to writeback over valid/ready. Holds operands stable for the whole operation. Sits between the ID-stage issue logic and the divider datapath.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fdiv_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_fdiv_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP divider types: error codes, issue-controller states and divider constants.
package fp_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        INVALID   = 3'd1,
        DIVBYZERO = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4,
        INEXACT   = 3'd5
    } o_err_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ITER  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } fdiv_ctrl_state_t;

    localparam int          FDIV_RESULT_LAT = 3;
    localparam logic [31:0] FP_QNAN         = 32'h7fc00000;

endpackage

// File: rtl/fdiv_issue_ctrl.sv
// Issues one divide at a time to the Newton divider and returns result/err/tag to writeback.
// Latency: accept -> rsp_valid_o = 1 + iteration window + RESULT_LAT + 1 cycles.
// Backpressure: req_ready_o only in IDLE; response held stable until rsp_ready_i. FDIV_WATCHDOG_EN adds an ITER timeout.
module fdiv_issue_ctrl
    import fp_pkg::*;
#(
    parameter int RESULT_LAT = FDIV_RESULT_LAT,
    parameter int TAG_W      = 5,
    parameter int CNT_W      = 16,
    parameter int MAX_ITER   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [1:0]       req_rm_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      div_a_o,
    output logic [31:0]      div_b_o,
    output logic [1:0]       div_rm_o,
    output logic             div_fdiv_o,
    output logic             div_ena_o,
    input  logic             div_busy_i,
    input  logic             div_stall_i,
    input  logic [31:0]      div_s_i,
    input  o_err_t           div_err_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_s_o,
    output o_err_t           rsp_err_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [CNT_W-1:0] done_cnt_o,
    output logic             ctrl_busy_o
);

    localparam int DW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    if (RESULT_LAT < 1 || MAX_ITER < 2) begin : g_param_chk
        $error("fdiv_issue_ctrl: RESULT_LAT must be >= 1 and MAX_ITER >= 2");
    end

    fdiv_ctrl_state_t state;
    logic [TAG_W-1:0] tag_q;
    logic [DW-1:0]    drain_cnt;
    logic             seen_stall;

`ifdef FDIV_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_ITER + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    assign req_ready_o = (state == IDLE);
    assign ctrl_busy_o = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tag_q       <= '0;
            drain_cnt   <= '0;
            seen_stall  <= 1'b0;
            div_a_o     <= '0;
            div_b_o     <= '0;
            div_rm_o    <= '0;
            div_fdiv_o  <= 1'b0;
            div_ena_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_s_o     <= '0;
            rsp_err_o   <= NONE;
            rsp_tag_o   <= '0;
            done_cnt_o  <= '0;
`ifdef FDIV_WATCHDOG_EN
            wd_cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        div_a_o    <= req_a_i;
                        div_b_o    <= req_b_i;
                        div_rm_o   <= req_rm_i;
                        tag_q      <= req_tag_i;
                        div_fdiv_o <= 1'b1;
                        div_ena_o  <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    div_fdiv_o <= 1'b0;
                    seen_stall <= 1'b0;
`ifdef FDIV_WATCHDOG_EN
                    wd_cnt     <= '0;
`endif
                    state      <= ITER;
                end
                ITER: begin
                    if (div_stall_i)
                        seen_stall <= 1'b1;
                    // Iteration is over only once a stall window has opened and closed.
                    if (seen_stall && !div_stall_i && !div_busy_i) begin
                        drain_cnt <= DW'(RESULT_LAT - 1);
                        state     <= DRAIN;
                    end
`ifdef FDIV_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(MAX_ITER - 1)) begin
                        rsp_s_o     <= FP_QNAN;
                        rsp_err_o   <= INVALID;
                        rsp_tag_o   <= tag_q;
                        div_ena_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        rsp_s_o     <= div_s_i;
                        rsp_err_o   <= div_err_i;
                        rsp_tag_o   <= tag_q;
                        div_ena_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        done_cnt_o  <= done_cnt_o + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Bench for fdiv_issue_ctrl: table vectors, random ops against a divider stub and latency model, reset/watchdog sequences.
module tb_fdiv_issue_ctrl;
    import fp_pkg::*;

    localparam int TAG_W    = 5;
    localparam int CNT_W    = 4;
    localparam int MAX_ITER = 32;
    localparam int RLAT     = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [31:0]      req_a_i = '0;
    logic [31:0]      req_b_i = '0;
    logic [1:0]       req_rm_i = '0;
    logic [TAG_W-1:0] req_tag_i = '0;
    logic [31:0]      div_a_o, div_b_o;
    logic [1:0]       div_rm_o;
    logic             div_fdiv_o, div_ena_o;
    logic             div_busy_i = 1'b0;
    logic             div_stall_i = 1'b0;
    logic [31:0]      div_s_i = '0;
    o_err_t           div_err_i = NONE;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [31:0]      rsp_s_o;
    o_err_t           rsp_err_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [CNT_W-1:0] done_cnt_o;
    logic             ctrl_busy_o;

    fdiv_issue_ctrl #(
        .RESULT_LAT(RLAT), .TAG_W(TAG_W), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_rm_o(div_rm_o),
        .div_fdiv_o(div_fdiv_o), .div_ena_o(div_ena_o),
        .div_busy_i(div_busy_i), .div_stall_i(div_stall_i),
        .div_s_i(div_s_i), .div_err_i(div_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_s_o(rsp_s_o), .rsp_err_o(rsp_err_o), .rsp_tag_o(rsp_tag_o),
        .done_cnt_o(done_cnt_o), .ctrl_busy_o(ctrl_busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Known quotients the divider stub can produce.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        o_err_t      err;
    } div_ent_t;
    div_ent_t dtab[8];

    // Stub timing for the next op: busy-only cycles, stall cycles, busy-only cycles.
    int st_p = 0, st_s = 1, st_b = 0;

    initial begin
        int mode = 0;
        int pl = 0, sl = 0, bl = 0, ecnt = 0;
        forever begin
            @(negedge clk);
            div_s_i   = $urandom;
            div_err_i = OVERFLOW;
            if (!rstn) begin
                mode = 0;
                div_stall_i = 1'b0;
                div_busy_i  = 1'b0;
            end else if (div_fdiv_o) begin
                mode = 1; pl = st_p; sl = st_s; bl = st_b;
                div_stall_i = 1'b0;
                div_busy_i  = 1'b1;
            end else if (mode == 1) begin
                if (pl > 0) begin
                    pl--; div_stall_i = 1'b0; div_busy_i = 1'b1;
                end else if (sl > 0) begin
                    sl--; div_stall_i = 1'b1; div_busy_i = 1'b1;
                end else if (bl > 0) begin
                    bl--; div_stall_i = 1'b0; div_busy_i = 1'b1;
                end else begin
                    div_stall_i = 1'b0; div_busy_i = 1'b0;
                    mode = 2; ecnt = 0;
                end
            end else begin
                div_stall_i = 1'($urandom_range(0, 1));
                div_busy_i  = 1'($urandom_range(0, 1));
                if (mode == 2) begin
                    if (div_ena_o) ecnt++;
                    if (ecnt == RLAT) begin
                        for (int i = 0; i < 8; i++)
                            if (dtab[i].a == div_a_o && dtab[i].b == div_b_o) begin
                                div_s_i   = dtab[i].q;
                                div_err_i = dtab[i].err;
                            end
                        mode = 0;
                    end
                end
            end
        end
    end

    // Runs one op from a negedge in IDLE back to a negedge in IDLE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input logic [TAG_W-1:0] tag, input int pp, input int ss, input int bb,
                         input int hold, input logic [31:0] exp_s, input o_err_t exp_err,
                         input bit chk_lat);
        int lat, exp_lat;
        bit ok_ops, ok_hold;
        exp_lat = 1 + (pp + ss + bb + 1) + RLAT + 1;
        st_p = pp; st_s = ss; st_b = bb;
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_a_i = a; req_b_i = b; req_rm_i = rm; req_tag_i = tag;
        @(negedge clk);
        req_valid_i = 1'b0; req_a_i = $urandom; req_b_i = $urandom;
        req_rm_i = ~rm; req_tag_i = ~tag;
        chk("fdiv_pulse", div_fdiv_o, 1);
        lat = 1;
        ok_ops = 1'b1;
        while (!rsp_valid_o && lat < 300) begin
            if (div_a_o !== a || div_b_o !== b || div_rm_o !== rm || req_ready_o !== 1'b0) ok_ops = 1'b0;
            if ((lat > 1 && div_fdiv_o) || !div_ena_o || !ctrl_busy_o) ok_ops = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid", rsp_valid_o, 1);
        if (chk_lat) chk("latency", lat, exp_lat);
        chk("operands_stable", ok_ops, 1);
        chk("rsp_s", rsp_s_o, exp_s);
        chk("rsp_err", rsp_err_o, exp_err);
        chk("rsp_tag", rsp_tag_o, tag);
        chk("resp_ena_low", div_ena_o, 0);
        ok_hold = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_s_o !== exp_s || rsp_err_o !== exp_err || rsp_tag_o !== tag ||
                req_ready_o !== 1'b0 || div_ena_o !== 1'b0 || done_cnt_o !== CNT_W'(model_cnt) ||
                div_a_o !== a)
                ok_hold = 1'b0;
        end
        if (hold > 0) chk("resp_hold", ok_hold, 1);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        chk("done_cnt", done_cnt_o, model_cnt);
        chk("rsp_valid_drop", rsp_valid_o, 0);
    endtask

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
        int               pp, ss, bb, hold;
        logic [31:0]      exp_s;
        o_err_t           exp_err;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int idx;
        bit quiet;
        dtab[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, NONE};
        dtab[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, DIVBYZERO};
        dtab[2] = '{32'h41200000, 32'h40A00000, 32'h40000000, NONE};
        dtab[3] = '{32'h3F800000, 32'h40000000, 32'h3F000000, NONE};
        dtab[4] = '{32'h41000000, 32'hC0800000, 32'hC0000000, NONE};
        dtab[5] = '{32'h00000000, 32'h00000000, 32'h7FC00000, INVALID};
        dtab[6] = '{32'h42C80000, 32'h41200000, 32'h41200000, NONE};
        dtab[7] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, INEXACT};

        vecs[0] = '{32'h40C00000, 32'h40000000, 2'd0, 5'd3,  0, 1, 0, 0, 32'h40400000, NONE};
        vecs[1] = '{32'h3F800000, 32'h00000000, 2'd1, 5'd7,  2, 3, 1, 0, 32'h7F800000, DIVBYZERO};
        vecs[2] = '{32'h41200000, 32'h40A00000, 2'd2, 5'd31, 0, 5, 4, 5, 32'h40000000, NONE};
        vecs[3] = '{32'h41000000, 32'hC0800000, 2'd3, 5'd0,  3, 1, 2, 1, 32'hC0000000, NONE};
        vecs[4] = '{32'h00000000, 32'h00000000, 2'd0, 5'd16, 1, 2, 0, 2, 32'h7FC00000, INVALID};
        vecs[5] = '{32'h3F800000, 32'h40400000, 2'd0, 5'd9,  0, 8, 3, 0, 32'h3EAAAAAB, INEXACT};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_ena", div_ena_o, 0);
        chk("rst_fdiv", div_fdiv_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
        chk("rst_err", rsp_err_o, NONE);
        chk("rst_busy", ctrl_busy_o, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            do_op(vecs[v].a, vecs[v].b, vecs[v].rm, vecs[v].tag, vecs[v].pp, vecs[v].ss,
                  vecs[v].bb, vecs[v].hold, vecs[v].exp_s, vecs[v].exp_err, 1'b1);

        // Enough random ops that the 4-bit completion counter wraps through 0.
        for (int n = 0; n < 14; n++) begin
            idx = $urandom_range(0, 7);
            do_op(dtab[idx].a, dtab[idx].b, 2'($urandom_range(0, 3)), TAG_W'($urandom),
                  $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 4),
                  $urandom_range(0, 3), dtab[idx].q, dtab[idx].err, 1'b1);
        end

        // Reset while the divider is iterating.
        st_p = 0; st_s = 20; st_b = 0;
        req_valid_i = 1'b1; req_a_i = dtab[2].a; req_b_i = dtab[2].b; req_tag_i = 5'd12;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_op_busy", ctrl_busy_o, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", req_ready_o, 1);
        chk("midrst_ena", div_ena_o, 0);
        chk("midrst_fdiv", div_fdiv_o, 0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_div_a", div_a_o, 0);
        chk("midrst_done_cnt", done_cnt_o, 0);
        model_cnt = 0;
        rstn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_o || div_fdiv_o || ctrl_busy_o || div_ena_o) quiet = 1'b0;
        end
        chk("no_reissue_after_reset", quiet, 1);

        do_op(dtab[6].a, dtab[6].b, 2'd1, 5'd21, 1, 2, 1, 1, dtab[6].q, dtab[6].err, 1'b1);

`ifdef FDIV_WATCHDOG_EN
        do_op(dtab[0].a, dtab[0].b, 2'd0, 5'd5, 0, MAX_ITER + 1, 0, 2, FP_QNAN, INVALID, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
